// File: rtl/npu_pool_pkg.sv
// npu_pool_pkg: constants, phase enum and compare helpers shared by the
// 2x2 max-pool stage.
// Macro POOL_RELU_EN: when defined, values compare as signed two's complement
// and relu() clamps negative maxima to zero. When undefined, values compare
// unsigned and relu() passes its input through.
package npu_pool_pkg;

  localparam int BIT_DEPTH = 8;
  localparam int ROW_PAIRS = 13;
  localparam int ADDR_W    = 5;

  // Which row of the 2x2 window an event belongs to (taken from comp2_en)
  typedef enum logic {
    ROW_A = 1'b0,
    ROW_B = 1'b1
  } phase_e;

  // Returns the larger of a and b. On a tie it returns a, so the caller passes
  // the buffered value as a to keep it.
  function automatic logic [BIT_DEPTH-1:0] max2(input logic [BIT_DEPTH-1:0] a,
                                                input logic [BIT_DEPTH-1:0] b);
    logic a_wins;
`ifdef POOL_RELU_EN
    a_wins = ($signed(a) >= $signed(b));
`else
    a_wins = (a >= b);
`endif
    return a_wins ? a : b;
  endfunction

  // Fused ReLU on the pooled value. Without the macro this is the identity.
  function automatic logic [BIT_DEPTH-1:0] relu(input logic [BIT_DEPTH-1:0] v);
`ifdef POOL_RELU_EN
    return v[BIT_DEPTH-1] ? {BIT_DEPTH{1'b0}} : v;
`else
    return v;
`endif
  endfunction

endpackage

// File: rtl/pool_row_buf.sv
// pool_row_buf: one-row buffer of partial maxima, with a valid bit per entry.
// Ports:
//   clk, rst          clock and asynchronous active-high reset (valid bits only)
//   clr_i             synchronous clear of every valid bit
//   idx_i             entry that is written and read this cycle
//   wr_en_i/wr_data_i store data at idx_i and set its valid bit
//   inv_en_i          clear the valid bit at idx_i
//   rd_data_o         asynchronous read of the entry at idx_i
//   rd_valid_o        valid bit of the entry at idx_i
module pool_row_buf #(
  parameter int DEPTH = 13,
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             inv_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Data storage. It has no reset because the valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (wr_en_i && !clr_i) begin
      mem_q[idx_i] <= wr_data_i;
    end
  end

  // Valid bits: reset and clear take priority over a set or an invalidate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {DEPTH{1'b0}};
    end else if (clr_i) begin
      valid_q <= {DEPTH{1'b0}};
    end else if (wr_en_i) begin
      valid_q[idx_i] <= 1'b1;
    end else if (inv_en_i) begin
      valid_q[idx_i] <= 1'b0;
    end
  end

  assign rd_data_o  = mem_q[idx_i];
  assign rd_valid_o = valid_q[idx_i];

endmodule

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: reduces each 2x2 neighbourhood of convolution results to its
// maximum and writes the result to the destination memory.
// A rising edge of comp1_en is one event. comp2_en selects the row:
//   ROW_A (comp2_en=0): store max(sum1,sum2) in the row buffer at idx.
//   ROW_B (comp2_en=1): write max(buf[idx],sum1,sum2) to pool_addr.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   start, in_dest_addr      begin a feature map and load the base address
//   sum1, sum2               left and right convolution results of a pair
//   comp1_en, comp2_en       pair strobe and row qualifier
//   pool_wr_en/addr/out      single-cycle write port
//   row_done                 one-cycle pulse after the last pair of a row
//   err                      sticky protocol error, cleared by rst or start
// Macro POOL_RELU_EN: signed compare plus ReLU clamp (see npu_pool_pkg).
module max_pool_2x2 #(
  parameter int BIT_DEPTH = npu_pool_pkg::BIT_DEPTH,
  parameter int ROW_PAIRS = npu_pool_pkg::ROW_PAIRS,
  parameter int ADDR_W    = npu_pool_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    in_dest_addr,
  input  logic [BIT_DEPTH-1:0] sum1,
  input  logic [BIT_DEPTH-1:0] sum2,
  input  logic                 comp1_en,
  input  logic                 comp2_en,
  output logic                 pool_wr_en,
  output logic [ADDR_W-1:0]    pool_addr,
  output logic [BIT_DEPTH-1:0] pool_out,
  output logic                 row_done,
  output logic                 err
);
  import npu_pool_pkg::*;

  localparam int IDX_W = (ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_PAIRS - 1);

  logic                 comp1_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 wr_en_q, wr_en_d;
  logic [BIT_DEPTH-1:0] out_q, out_d;
  logic                 row_done_q, row_done_d;
  logic                 err_q, err_d;

  logic                 event_s;
  phase_e               phase_s;
  logic [BIT_DEPTH-1:0] pair_max_s;
  logic [BIT_DEPTH-1:0] win_max_s;
  logic [BIT_DEPTH-1:0] buf_rd_s;
  logic                 buf_valid_s;
  logic                 buf_wr_s;
  logic                 buf_inv_s;

  pool_row_buf #(
    .DEPTH(ROW_PAIRS),
    .WIDTH(BIT_DEPTH),
    .IDX_W(IDX_W)
  ) u_row_buf (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (start),
    .idx_i     (idx_q),
    .wr_en_i   (buf_wr_s),
    .wr_data_i (pair_max_s),
    .inv_en_i  (buf_inv_s),
    .rd_data_o (buf_rd_s),
    .rd_valid_o(buf_valid_s)
  );

  // Next-state logic: event decode, index and address counters, write port, error flag
  always_comb begin
    event_s    = comp1_en & ~comp1_q;
    phase_s    = comp2_en ? ROW_B : ROW_A;
    pair_max_s = max2(sum1, sum2);
    // The buffered value goes first so that it wins a tie
    win_max_s  = buf_valid_s ? max2(buf_rd_s, pair_max_s) : pair_max_s;

    idx_d      = idx_q;
    // The address steps in the cycle after a write strobe
    addr_d     = wr_en_q ? (addr_q + ADDR_W'(1)) : addr_q;
    wr_en_d    = 1'b0;
    out_d      = out_q;
    row_done_d = 1'b0;
    err_d      = err_q;
    buf_wr_s   = 1'b0;
    buf_inv_s  = 1'b0;

    if (start) begin
      // start takes priority, so an event in the same cycle is dropped
      idx_d  = {IDX_W{1'b0}};
      addr_d = in_dest_addr;
      out_d  = {BIT_DEPTH{1'b0}};
      err_d  = 1'b0;
    end else if (event_s) begin
      if (idx_q == LAST_IDX) begin
        idx_d      = {IDX_W{1'b0}};
        row_done_d = 1'b1;
      end else begin
        idx_d      = idx_q + IDX_W'(1);
        row_done_d = 1'b0;
      end
      case (phase_s)
        ROW_A: begin
          buf_wr_s = 1'b1;
          // The entry already holds a value, which ROW_A overwrites
          if (buf_valid_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
        ROW_B: begin
          wr_en_d   = 1'b1;
          out_d     = relu(win_max_s);
          buf_inv_s = 1'b1;
          // No matching ROW_A value, so only the incoming pair is used
          if (!buf_valid_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
    end else begin
      idx_d = idx_q;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp1_q    <= 1'b0;
      idx_q      <= {IDX_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      wr_en_q    <= 1'b0;
      out_q      <= {BIT_DEPTH{1'b0}};
      row_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      comp1_q    <= comp1_en;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      out_q      <= out_d;
      row_done_q <= row_done_d;
      err_q      <= err_d;
    end
  end

  assign pool_wr_en = wr_en_q;
  assign pool_addr  = addr_q;
  assign pool_out   = out_q;
  assign row_done   = row_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// tb_max_pool_2x2: directed scoreboard bench for max_pool_2x2.
// When stimulus is issued, the expected write is queued. A negedge monitor
// pops the queue on each pool_wr_en and compares the address and the data.
module tb_max_pool_2x2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] in_dest_addr;
  logic [7:0] sum1, sum2;
  logic       comp1_en, comp2_en;
  logic       pool_wr_en;
  logic [4:0] pool_addr;
  logic [7:0] pool_out;
  logic       row_done;
  logic       err;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  // Hand-computed row data: ROW_A pairs, ROW_B pairs and the pooled maxima
  logic [7:0] a1 [13] = '{8'd10, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100,
                          8'd110, 8'd120, 8'd130, 8'd140, 8'd150, 8'd160};
  logic [7:0] a2 [13] = '{8'd30, 8'd55, 8'd65, 8'd75, 8'd85, 8'd95, 8'd105,
                          8'd115, 8'd125, 8'd135, 8'd145, 8'd155, 8'd165};
  logic [7:0] b1 [13] = '{8'd25, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100, 8'd110,
                          8'd120, 8'd130, 8'd140, 8'd150, 8'd160, 8'd170};
  logic [7:0] b2 [13] = '{8'd20, 8'd52, 8'd62, 8'd72, 8'd82, 8'd92, 8'd102,
                          8'd112, 8'd122, 8'd132, 8'd142, 8'd152, 8'd162};
  logic [7:0] ex [13] = '{8'd30, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100, 8'd110,
                          8'd120, 8'd130, 8'd140, 8'd150, 8'd160, 8'd170};

  max_pool_2x2 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_dest_addr(in_dest_addr),
    .sum1        (sum1),
    .sum2        (sum2),
    .comp1_en    (comp1_en),
    .comp2_en    (comp2_en),
    .pool_wr_en  (pool_wr_en),
    .pool_addr   (pool_addr),
    .pool_out    (pool_out),
    .row_done    (row_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe event (high one cycle, then low one cycle)
  task automatic ev(input logic ph_b, input logic [7:0] s1, input logic [7:0] s2);
    sum1 = s1; sum2 = s2; comp2_en = ph_b; comp1_en = 1'b1;
    tick();
    comp1_en = 1'b0; comp2_en = 1'b0;
    tick();
  endtask

  task automatic do_start(input logic [4:0] a);
    start = 1'b1; in_dest_addr = a;
    tick();
    start = 1'b0;
  endtask

  function automatic void push(input logic [4:0] a, input logic [7:0] d);
    exp_t e;
    e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  // Monitor: compare each write against the oldest expected entry
  always @(negedge clk) begin
    if (!rst) begin
      if (pool_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                   pool_addr, pool_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(pool_addr), 32'(e.addr));
          chk("wr_data", 32'(pool_out), 32'(e.data));
        end
      end
      if (row_done) rd_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] relu_exp;
    rst = 1'b1; start = 1'b0; in_dest_addr = 5'd0;
    sum1 = 8'd0; sum2 = 8'd0; comp1_en = 1'b0; comp2_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_wr_en", 32'(pool_wr_en), 32'd0);
    chk("reset_addr", 32'(pool_addr), 32'd0);
    chk("reset_out", 32'(pool_out), 32'd0);
    chk("reset_row_done", 32'(row_done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // Start at base address 4
    do_start(5'd4);
    chk("start_addr", 32'(pool_addr), 32'd4);
    chk("start_out", 32'(pool_out), 32'd0);

    // Full row: 13 ROW_A events, then 13 ROW_B events
    rd_cnt = 0;
    for (int i = 0; i < 13; i++) ev(1'b0, a1[i], a2[i]);
    chk("row_done_after_a", 32'(rd_cnt), 32'd1);
    for (int i = 0; i < 13; i++) begin
      push(5'(4 + i), ex[i]);
      ev(1'b1, b1[i], b2[i]);
      if (i == 0) chk("addr_after_first_wr", 32'(pool_addr), 32'd5);
    end
    chk("row_done_after_b", 32'(rd_cnt), 32'd2);
    chk("addr_after_row", 32'(pool_addr), 32'd17);
    chk("err_clean_row", 32'(err), 32'd0);

    // ROW_B at an empty index uses the pair alone and sets err
    push(5'd17, 8'd9);
    ev(1'b1, 8'd7, 8'd9);
    chk("empty_b_out", 32'(pool_out), 32'd9);
    chk("empty_b_err", 32'(err), 32'd1);
    repeat (3) tick();
    chk("err_sticky", 32'(err), 32'd1);
    do_start(5'd20);
    chk("err_cleared_by_start", 32'(err), 32'd0);
    chk("start2_addr", 32'(pool_addr), 32'd20);

    // comp1_en held high for 3 cycles counts as one event
    sum1 = 8'd5; sum2 = 8'd6; comp2_en = 1'b0; comp1_en = 1'b1;
    repeat (3) tick();
    comp1_en = 1'b0;
    tick();
    rd_cnt = 0;
    for (int i = 0; i < 11; i++) ev(1'b0, 8'd1, 8'd1);
    chk("held_no_early_wrap", 32'(rd_cnt), 32'd0);
    ev(1'b0, 8'd1, 8'd1);
    chk("held_wrap_at_13", 32'(rd_cnt), 32'd1);
    push(5'd20, 8'd6);
    ev(1'b1, 8'd1, 8'd2);
    chk("held_err", 32'(err), 32'd0);

    // comp2_en level-high without a comp1_en event is ignored
    comp2_en = 1'b1;
    repeat (4) tick();
    comp2_en = 1'b0;
    tick();
    chk("lvl_comp2_err", 32'(err), 32'd0);
    chk("lvl_comp2_addr", 32'(pool_addr), 32'd21);

    // start in the same cycle as an event: the event is dropped
    sum1 = 8'd3; sum2 = 8'd4; comp2_en = 1'b1; comp1_en = 1'b1;
    start = 1'b1; in_dest_addr = 5'd24;
    tick();
    start = 1'b0; comp1_en = 1'b0; comp2_en = 1'b0;
    tick();
    chk("start_event_err", 32'(err), 32'd0);
    chk("start_event_addr", 32'(pool_addr), 32'd24);

    // Negative values: signed compare and ReLU clamp with the macro, unsigned without it
`ifdef POOL_RELU_EN
    relu_exp = 8'h00;
`else
    relu_exp = 8'hFE;
`endif
    for (int i = 0; i < 13; i++) ev(1'b0, 8'hF0, 8'hF8);
    push(5'd24, relu_exp);
    ev(1'b1, 8'hFE, 8'h80);
    chk("relu_out", 32'(pool_out), 32'(relu_exp));
    chk("relu_err", 32'(err), 32'd0);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("write_count", 32'(wr_cnt), 32'd16);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/max_pool_2x2.md
# max_pool_2x2

Downstream stage of the convolution engine. Consumes the two horizontally adjacent convolution results (`sum1`, `sum2`) that the engine presents with its `comp1_en`/`comp2_en` strobes. Reduces each 2x2 neighbourhood to its maximum using a one-row buffer of partial maxima. Each pooled value is written to the destination memory through a single-cycle write port.

## Interface

Parameters:

- `BIT_DEPTH`, 8: data width of sums and pooled output.
- `ROW_PAIRS`, 13: column pairs per conv output row (26/2); row-buffer depth.
- `ADDR_W`, 5: destination address width.

Ports:

- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a new feature map; captures `in_dest_addr`, clears index and buffer valid bits.
- `in_dest_addr`, in, ADDR_W: base address of the pooled output.
- `sum1`, in, BIT_DEPTH: left conv result of the pair.
- `sum2`, in, BIT_DEPTH: right conv result of the pair.
- `comp1_en`, in, 1: pair strobe.
- `comp2_en`, in, 1: qualifier; high together with `comp1_en` marks the second row of the pool window.
- `pool_wr_en`, out, 1: one-cycle write strobe.
- `pool_addr`, out, ADDR_W: write address.
- `pool_out`, out, BIT_DEPTH: pooled maximum.
- `row_done`, out, 1: one-cycle pulse after the last pair of a row.
- `err`, out, 1: sticky protocol error.

## Operation

**Strobe detection**
- An event occurs on a rising edge of `comp1_en` (high this cycle, low the previous cycle).
- A strobe held high for several cycles counts as one event.
- `comp2_en` is sampled in the event cycle.

**Phase ROW_A** (event with `comp2_en`=0)
- `buf[idx] <= max(sum1,sum2)`.
- `valid[idx] <= 1`.
- `idx` increments.

**Phase ROW_B** (event with `comp2_en`=1)
- `pool_out <= max(buf[idx], sum1, sum2)`.
- `pool_wr_en` pulses.
- `valid[idx] <= 0`.
- `idx` increments.

**Index wrap**
- When `idx` = ROW_PAIRS-1 and an event occurs: `idx` returns to 0 and `row_done` pulses the next cycle.

**Address**
- `pool_addr` is loaded from `in_dest_addr` on `start`.
- It holds the current write address and increments by 1 in the cycle after each `pool_wr_en`.
- It wraps modulo 2^ADDR_W.

**Comparison**
- Unsigned, full BIT_DEPTH, no widening.
- Ties keep the buffered value.

**Boundary conditions**
- ROW_B event with `valid[idx]`=0: output `max(sum1,sum2)`, write still issued, `err` set.
- ROW_A event with `valid[idx]`=1: overwrite, `err` set.
- Level-high `comp2_en` without a `comp1_en` event: ignored, no error.
- `start` coincident with an event: `start` wins and the event is dropped.
- `err` clears only on `rst` or `start`.

**Reset**
- All outputs are 0 and `idx` is 0.
- All valid bits are cleared; buffer data is don't-care.
- The edge-detect history register is cleared to 0, so `comp1_en` high at reset release counts as an event.

## Timing

- Event in cycle N: buffer update, or `pool_out`/`pool_wr_en`, is registered at the end of N and visible in N+1.
- `pool_addr` in N+1 is the write address; it advances in N+2.
- Latency from strobe to write is 1 cycle.
- Throughput is one event every 2 cycles. A new rising edge needs at least one low cycle; the engine's strobe pattern (high 1 cycle, then low) satisfies this.
- `row_done` is asserted in N+1 alongside any `pool_wr_en`.
- `start` takes effect at the end of its cycle; the next cycle is a clean state.

## Configuration

- `POOL_RELU_EN` defined:
  - `sum1`, `sum2` and buffered values are treated as signed two's complement; comparison is signed.
  - `pool_out` is clamped to 0 when the maximum is negative (fused ReLU).
- Not defined: unsigned compare, no clamp, as in Operation.

## Structure

- Shared package `npu_pool_pkg`:
  - default constants `BIT_DEPTH`, `ROW_PAIRS`, `ADDR_W`.
  - a `max2` function, signedness selected under `POOL_RELU_EN`.
  - phase enum `{ROW_A, ROW_B}`.
- One sub-module, `pool_row_buf`:
  - ROW_PAIRS x BIT_DEPTH register array plus valid bits.
  - one write and one asynchronous read at `idx`.
  - synchronous clear of valid bits.
- Top holds the edge detect, index counter, address counter, output registers and error flag.

## Test plan

- Reset, then `start` with `in_dest_addr`=4 -> all outputs 0, `pool_addr`=4.
- ROW_A pair (10,30), then ROW_B pair (25,20) at the same index -> `pool_out`=30, `pool_wr_en` for 1 cycle at addr 4, then `pool_addr`=5.
- 13 ROW_A events then 13 ROW_B events with increasing data -> 13 writes at addr 4..16, `row_done` pulsed twice, `err`=0.
- ROW_B event at an empty index with pair (7,9) -> `pool_out`=9, `err`=1 sticky until `start`.
- `comp1_en` held high for 3 cycles -> exactly one event and `idx` advances by 1; `start` in the same cycle as an event -> event dropped.
- With `POOL_RELU_EN`: ROW_A (0xF0,0xF8), then ROW_B (0xFE,0x80) -> `pool_out`=0 (all values negative); without the macro the same stimulus gives `pool_out`=0xFE.
